// File: rtl/optical_flow_sequencer.sv
`default_nettype none
//==============================================================================
// Module : optical_flow_sequencer
// Brief  : Frame sequencer for the LK flow pipeline. It paces pixel issue with
//          credits, tags each result with x/y/sof/eol/eof and streams the
//          results out of a first-word-fall-through FIFO.
// Option : OPTICAL_FLOW_SEQ_PROTO_CHECK_EN adds the sticky proto_err output.
// Rev    : 1.0  initial release
//==============================================================================
module optical_flow_sequencer #(
  parameter int IMAGE_WIDTH     = 320,
  parameter int IMAGE_HEIGHT    = 240,
  parameter int FLOW_WIDTH      = 16,
  parameter int FIFO_DEPTH      = 16,
  parameter int MAX_INFLIGHT    = 64,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            continuous,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic [FRAME_CNT_WIDTH-1:0]      frame_cnt,
  input  logic                            src_valid,
  output logic                            src_ready,
  output logic                            pe_valid,
  input  logic                            dp_valid,
  input  logic signed [FLOW_WIDTH-1:0]    dp_u,
  input  logic signed [FLOW_WIDTH-1:0]    dp_v,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  m_x,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] m_y,
  output logic signed [FLOW_WIDTH-1:0]    m_u,
  output logic signed [FLOW_WIDTH-1:0]    m_v,
  output logic                            m_sof,
  output logic                            m_eol,
`ifdef OPTICAL_FLOW_SEQ_PROTO_CHECK_EN
  output logic                            m_eof,
  output logic                            proto_err
`else
  output logic                            m_eof
`endif
);

  localparam int c_XW   = $clog2(IMAGE_WIDTH);
  localparam int c_YW   = $clog2(IMAGE_HEIGHT);
  localparam int c_NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int c_IW   = $clog2(c_NPIX + 1);
  localparam int c_FW   = $clog2(MAX_INFLIGHT + 1);
  localparam int c_PW   = $clog2(FIFO_DEPTH);
  localparam int c_CW   = $clog2(FIFO_DEPTH + 1);
  localparam int c_EW   = c_XW + c_YW + 2 * FLOW_WIDTH + 3;

  localparam logic [c_XW-1:0] c_XLAST   = c_XW'(IMAGE_WIDTH - 1);
  localparam logic [c_YW-1:0] c_YLAST   = c_YW'(IMAGE_HEIGHT - 1);
  localparam logic [c_IW-1:0] c_NPIX_V  = c_IW'(c_NPIX);
  localparam logic [c_IW-1:0] c_NPIX_M1 = c_IW'(c_NPIX - 1);
  localparam logic [c_FW-1:0] c_MAXIF   = c_FW'(MAX_INFLIGHT);
  localparam logic [31:0]     c_DEPTH   = 32'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [c_IW-1:0]            r_issued;
  logic [c_FW-1:0]            r_inflight;
  logic                       r_cont;
  logic [c_XW-1:0]            r_px;
  logic [c_YW-1:0]            r_py;
  logic [FRAME_CNT_WIDTH-1:0] r_frame_cnt;
  logic [c_EW-1:0]            r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]            r_wr_ptr;
  logic [c_PW-1:0]            r_rd_ptr;
  logic [c_CW-1:0]            r_cnt;

  logic            w_dp_take;
  logic            w_push;
  logic            w_pop;
  logic            w_start_ok;
  logic            w_run_enter;
  logic            w_issue_done;
  logic            w_sof;
  logic            w_eol;
  logic            w_eof;
  logic [31:0]     w_credit;
  logic [c_EW-1:0] w_entry;

  // Credits count both FIFO occupancy and results still inside the datapath,
  // so every issued pixel already owns a FIFO slot.
  assign w_credit  = 32'(r_cnt) + 32'(r_inflight);
  assign src_ready = (r_state == S_RUN) && (r_issued < c_NPIX_V) &&
                     (r_inflight < c_MAXIF) && (w_credit < c_DEPTH);
  assign pe_valid  = src_valid & src_ready;

  assign w_dp_take = dp_valid && (r_inflight != '0);
  assign w_push    = w_dp_take && ((r_state == S_RUN) || (r_state == S_DRAIN));
  assign m_valid   = (r_cnt != '0);
  assign w_pop     = m_valid & m_ready;

  assign w_start_ok   = !abort && (r_state == S_IDLE) && start;
  assign w_run_enter  = w_start_ok || (!abort && (r_state == S_DONE) && r_cont);
  assign w_issue_done = (r_issued == c_NPIX_V) || (pe_valid && (r_issued == c_NPIX_M1));

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE) && !abort;
  assign frame_cnt = r_frame_cnt;

  assign w_sof   = (r_px == '0) && (r_py == '0);
  assign w_eol   = (r_px == c_XLAST);
  assign w_eof   = w_eol && (r_py == c_YLAST);
  assign w_entry = {r_px, r_py, dp_u, dp_v, w_sof, w_eol, w_eof};

  assign {m_x, m_y, m_u, m_v, m_sof, m_eol, m_eof} = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (abort && (r_state != S_FLUSH)) begin
      w_state_nx = S_FLUSH;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_state_nx = S_RUN;
        S_RUN:   if (w_issue_done) w_state_nx = S_DRAIN;
        S_DRAIN: if (w_pop && m_eof) w_state_nx = S_DONE;
        S_DONE:  w_state_nx = r_cont ? S_RUN : S_IDLE;
        S_FLUSH: if (r_inflight == '0) w_state_nx = S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issued    <= '0;
      r_inflight  <= '0;
      r_cont      <= 1'b0;
      r_px        <= '0;
      r_py        <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_inflight <= r_inflight + c_FW'(pe_valid) - c_FW'(w_dp_take);

      if (w_start_ok)  r_cont <= continuous;
      else if (abort)  r_cont <= 1'b0;

      if (w_run_enter)   r_issued <= '0;
      else if (pe_valid) r_issued <= r_issued + 1'b1;

      // Push-side raster position; restarts at 0,0 for each frame.
      if (w_run_enter) begin
        r_px <= '0;
        r_py <= '0;
      end else if (w_push) begin
        if (r_px == c_XLAST) begin
          r_px <= '0;
          r_py <= (r_py == c_YLAST) ? '0 : r_py + 1'b1;
        end else begin
          r_px <= r_px + 1'b1;
        end
      end

      if (done) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt <= r_cnt + c_CW'(w_push) - c_CW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

`ifdef OPTICAL_FLOW_SEQ_PROTO_CHECK_EN
  logic w_spurious;
  logic w_overissue;

  assign w_spurious  = dp_valid && (r_inflight == '0);
  assign w_overissue = pe_valid && (r_issued >= c_NPIX_V);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   proto_err <= 1'b0;
    else if (w_spurious || w_overissue)        proto_err <= 1'b1;
    else if (start && (r_state == S_IDLE))     proto_err <= 1'b0;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_optical_flow_sequencer.sv
`default_nettype none
//==============================================================================
// Module : tb_optical_flow_sequencer
// Brief  : Directed bench for optical_flow_sequencer with a 3-cycle echo
//          datapath (W=4, H=3, FIFO_DEPTH=4, MAX_INFLIGHT=8, 2-bit frame_cnt).
// Rev    : 1.0  initial release
//==============================================================================
module tb_optical_flow_sequencer;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int FD  = 4;
  localparam int MI  = 8;
  localparam int FW  = 16;
  localparam int FCW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start, continuous, abort, src_valid, m_ready, inject;
  logic busy, done, src_ready, pe_valid, dp_valid, m_valid;
  logic m_sof, m_eol, m_eof;
  logic [FCW-1:0] frame_cnt;
  logic [FW-1:0]  dp_u, dp_v, m_u, m_v;
  logic [1:0]     m_x, m_y;
`ifdef OPTICAL_FLOW_SEQ_PROTO_CHECK_EN
  logic proto_err;
`endif

  always #5 clk = ~clk;

  optical_flow_sequencer #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FLOW_WIDTH(FW),
    .FIFO_DEPTH(FD), .MAX_INFLIGHT(MI), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .busy(busy), .done(done), .frame_cnt(frame_cnt),
    .src_valid(src_valid), .src_ready(src_ready), .pe_valid(pe_valid),
    .dp_valid(dp_valid), .dp_u(dp_u), .dp_v(dp_v),
    .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y),
    .m_u(m_u), .m_v(m_v), .m_sof(m_sof), .m_eol(m_eol),
`ifdef OPTICAL_FLOW_SEQ_PROTO_CHECK_EN
    .m_eof(m_eof), .proto_err(proto_err)
`else
    .m_eof(m_eof)
`endif
  );

  // Echo datapath: the result for an issue is its global issue number.
  logic [2:0]    pv;
  logic [FW-1:0] pd [3];
  int unsigned   iss_seq;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv      <= '0;
      iss_seq <= 0;
      for (int i = 0; i < 3; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[1:0], pe_valid};
      pd[0] <= FW'(iss_seq);
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      if (pe_valid) iss_seq <= iss_seq + 1;
    end
  end

  assign dp_valid = pv[2] | inject;
  assign dp_u     = pd[2];
  assign dp_v     = pd[2] ^ 16'h5A5A;

  typedef struct packed {
    logic [1:0]    x;
    logic [1:0]    y;
    logic [FW-1:0] u;
    logic [FW-1:0] v;
    logic [2:0]    f;
  } beat_t;

  beat_t beats[$];
  int    done_cnt = 0;

  always @(negedge clk) begin
    if (m_valid && m_ready) beats.push_back('{m_x, m_y, m_u, m_v, {m_sof, m_eol, m_eof}});
    if (done) done_cnt++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(busy), 64'd0);
  endtask

  // Expected beat k: raster coordinate and the issue number base+k.
  task automatic check_frame(input int first, input int n, input int unsigned base, input string tag);
    beat_t e;
    for (int k = 0; k < n; k++) begin
      e.x = 2'(k % W);
      e.y = 2'((k / W) % H);
      e.u = FW'(base + k);
      e.v = e.u ^ 16'h5A5A;
      e.f = {((k % (W*H)) == 0), ((k % W) == W-1), ((k % (W*H)) == W*H-1)};
      if (first + k < beats.size()) chk(tag, 64'(beats[first+k]), 64'(e));
      else chk({tag, "_missing"}, 64'(first + k), 64'(beats.size()));
    end
  endtask

  int unsigned base;
  int          n0, nabort;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 0; continuous = 0; abort = 0; src_valid = 0; m_ready = 0; inject = 0;
    tick(3);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_frame_cnt", 64'(frame_cnt), 0);
    chk("rst_src_ready", 64'(src_ready), 0);
    chk("rst_m_valid", 64'(m_valid), 0);
    chk("rst_m_out", 64'({m_x, m_y, m_u, m_v, m_sof, m_eol, m_eof}), 0);
`ifdef OPTICAL_FLOW_SEQ_PROTO_CHECK_EN
    chk("rst_proto_err", 64'(proto_err), 0);
`endif
    rst = 0;
    tick(2);
    chk("idle_busy", 64'(busy), 0);

    // 1: single frame, free-flowing output
    src_valid = 1; m_ready = 1; base = iss_seq; n0 = beats.size();
    start = 1; tick(1); start = 0;
    wait_done(1, 200, "t1_done_timeout");
    chk("t1_busy", 64'(busy), 0);
    chk("t1_frame_cnt", 64'(frame_cnt), 1);
    chk("t1_beats", 64'(beats.size() - n0), 12);
    check_frame(n0, 12, base, "t1_beat");
    tick(3);
    chk("t1_done_once", 64'(done_cnt), 1);
`ifdef OPTICAL_FLOW_SEQ_PROTO_CHECK_EN
    chk("t1_proto_clean", 64'(proto_err), 0);
`endif

    // spurious result with nothing outstanding
    n0 = beats.size();
    inject = 1; tick(1); inject = 0;
    tick(2);
    chk("spur_m_valid", 64'(m_valid), 0);
    chk("spur_beats", 64'(beats.size()), 64'(n0));
`ifdef OPTICAL_FLOW_SEQ_PROTO_CHECK_EN
    chk("t6_proto_set", 64'(proto_err), 1);
    tick(3);
    chk("t6_proto_sticky", 64'(proto_err), 1);
`endif

    // 2: backpressure
    m_ready = 0; base = iss_seq; n0 = beats.size();
    start = 1; tick(1); start = 0;
`ifdef OPTICAL_FLOW_SEQ_PROTO_CHECK_EN
    chk("t6_proto_cleared", 64'(proto_err), 0);
`endif
    tick(20);
    chk("t2_issues", 64'(iss_seq - base), 4);
    chk("t2_src_ready", 64'(src_ready), 0);
    chk("t2_m_valid", 64'(m_valid), 1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold", 64'({m_x, m_y, m_u, m_v, m_sof, m_eol, m_eof}),
          64'({2'd0, 2'd0, FW'(base), FW'(base) ^ 16'h5A5A, 3'b100}));
      tick(1);
    end
    m_ready = 1;
    wait_done(2, 200, "t2_done_timeout");
    chk("t2_beats", 64'(beats.size() - n0), 12);
    check_frame(n0, 12, base, "t2_beat");
    chk("t2_frame_cnt", 64'(frame_cnt), 2);

    // 3: continuous, three frames, abort during the fourth
    base = iss_seq; n0 = beats.size();
    continuous = 1; start = 1; tick(1); start = 0; continuous = 0;
    wait_done(5, 600, "t3_done_timeout");
    chk("t3_frame_cnt_wrap", 64'(frame_cnt), 1);
    chk("t3_run_again", 64'(busy), 1);
    tick(4);
    abort = 1; tick(1); abort = 0;
    chk("t3_flush_m_valid", 64'(m_valid), 0);
    chk("t3_flush_busy", 64'(busy), 1);
    chk("t3_flush_src_ready", 64'(src_ready), 0);
    nabort = beats.size();
    wait_idle(50, "t3_idle_timeout");
    chk("t3_no_done", 64'(done_cnt), 5);
    chk("t3_frame_cnt", 64'(frame_cnt), 1);
    chk("t3_no_pop_flush", 64'(beats.size()), 64'(nabort));
    check_frame(n0, 36, base, "t3_beat");

    // 4: abort with three results in flight
    src_valid = 0; base = iss_seq; n0 = beats.size();
    start = 1; tick(1); start = 0;
    src_valid = 1; tick(3); src_valid = 0;
    chk("t4_issues", 64'(iss_seq - base), 3);
    abort = 1; tick(1); abort = 0;
    chk("t4_flush_m_valid", 64'(m_valid), 0);
    chk("t4_flush_busy", 64'(busy), 1);
    wait_idle(20, "t4_idle_timeout");
    tick(3);
    chk("t4_discarded", 64'(beats.size()), 64'(n0));
    src_valid = 1; base = iss_seq; n0 = beats.size();
    start = 1; tick(1); start = 0;
    wait_done(6, 200, "t4_done_timeout");
    chk("t4_beats", 64'(beats.size() - n0), 12);
    check_frame(n0, 12, base, "t4_beat");
    chk("t4_frame_cnt", 64'(frame_cnt), 2);

    // 5: start while running, then start+abort in IDLE
    base = iss_seq; n0 = beats.size();
    start = 1; tick(1); start = 0;
    tick(3);
    start = 1; tick(1); start = 0;
    wait_done(7, 200, "t5_done_timeout");
    chk("t5_busy", 64'(busy), 0);
    tick(30);
    chk("t5_still_idle", 64'(busy), 0);
    chk("t5_done_cnt", 64'(done_cnt), 7);
    chk("t5_beats", 64'(beats.size() - n0), 12);
    check_frame(n0, 12, base, "t5_beat");
    chk("t5_frame_cnt", 64'(frame_cnt), 3);
    base = iss_seq;
    start = 1; abort = 1; tick(1); start = 0; abort = 0;
    chk("t5_sa_flush", 64'(busy), 1);
    chk("t5_sa_src_ready", 64'(src_ready), 0);
    tick(1);
    chk("t5_sa_idle", 64'(busy), 0);
    tick(20);
    chk("t5_sa_no_issue", 64'(iss_seq - base), 0);
    chk("t5_sa_done_cnt", 64'(done_cnt), 7);
    chk("t5_sa_frame_cnt", 64'(frame_cnt), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
